// File: rtl/axi_node_pkg.sv
// Shared AXI node types: error-sink FSM encoding and fixed response codes.
`timescale 1ns/1ps
package axi_node_pkg;

  localparam int AXI_LEN_W = 8;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_RESP  = 3'd4
  } err_state_e;

endpackage

// File: rtl/axi_w_error_sink.sv
// Absorbs the W burst of an AW that decoded to no slave and answers it with DECERR.
`timescale 1ns/1ps
module axi_w_error_sink
  import axi_node_pkg::*;
#(
  parameter int AXI_ID_IN  = 16,
  parameter int AXI_USER_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AXI_ID_IN-1:0]  awid_i,
  input  logic [AXI_LEN_W-1:0]  awlen_i,
  input  logic                  sample_awdata_info_i,
  input  logic                  handle_error_i,
  output logic                  wdata_error_completed_o,
  input  logic                  error_req_i,
  output logic                  error_gnt_o,
  input  logic                  wvalid_i,
  input  logic                  wlast_i,
  output logic                  wready_o,
  output logic                  bvalid_o,
  output logic [AXI_ID_IN-1:0]  bid_o,
  output logic [1:0]            bresp_o,
  output logic [AXI_USER_W-1:0] buser_o,
  input  logic                  bready_i,
  output logic                  wlast_err_o
);

  err_state_e             state_q, state_d;
  logic [AXI_ID_IN-1:0]   id_q, id_d;
  logic [AXI_LEN_W-1:0]   len_q, len_d;
  // One bit wider than the length so a 256-beat burst never wraps.
  logic [AXI_LEN_W:0]     cnt_q, cnt_d;

  logic w_beat, w_final, b_hs;

  assign w_beat  = (state_q == ST_DRAIN) & wvalid_i;
  assign w_final = w_beat & (cnt_q == {1'b0, len_q});
  assign b_hs    = (state_q == ST_RESP) & error_req_i & bready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Burst end is decided by the beat count alone; WLAST is only audited.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sample_awdata_info_i) begin
          id_d    = awid_i;
          len_d   = awlen_i;
          cnt_d   = '0;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: if (handle_error_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (w_beat) begin
          cnt_d = cnt_q + 1'b1;
          if (w_final) state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_RESP;
      ST_RESP:  if (b_hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wready_o                = (state_q == ST_DRAIN);
    wdata_error_completed_o = (state_q == ST_DONE);
    bvalid_o                = (state_q == ST_RESP) & error_req_i;
    error_gnt_o             = b_hs;
    wlast_err_o             = w_beat & (wlast_i ^ w_final);
    bid_o                   = id_q;
    bresp_o                 = RESP_DECERR;
    buser_o                 = '0;
  end

endmodule

// File: tb/tb_axi_w_error_sink.sv
// Scoreboard bench: stimulus queues expected W-beat/completion/B outcomes, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_axi_w_error_sink;
  localparam int IDW = 16;
  localparam int UW  = 6;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [IDW-1:0] awid_i = '0;
  logic [7:0]     awlen_i = '0;
  logic sample_awdata_info_i = 1'b0, handle_error_i = 1'b0, error_req_i = 1'b0;
  logic wvalid_i = 1'b0, wlast_i = 1'b0, bready_i = 1'b0;
  logic wdata_error_completed_o, error_gnt_o, wready_o, bvalid_o, wlast_err_o;
  logic [IDW-1:0] bid_o;
  logic [1:0]     bresp_o;
  logic [UW-1:0]  buser_o;

  int n_chk = 0, n_fail = 0, cyc = 0, beats = 0, final_cyc = -10;

  typedef struct { bit err; bit fin; } beat_t;
  beat_t          wq[$];
  int             cq[$];
  logic [IDW-1:0] bq[$];

  always #5 clk = ~clk;

  axi_w_error_sink #(.AXI_ID_IN(IDW), .AXI_USER_W(UW)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid_i(awid_i), .awlen_i(awlen_i),
    .sample_awdata_info_i(sample_awdata_info_i), .handle_error_i(handle_error_i),
    .wdata_error_completed_o(wdata_error_completed_o),
    .error_req_i(error_req_i), .error_gnt_o(error_gnt_o),
    .wvalid_i(wvalid_i), .wlast_i(wlast_i), .wready_o(wready_o),
    .bvalid_o(bvalid_o), .bid_o(bid_o), .bresp_o(bresp_o), .buser_o(buser_o),
    .bready_i(bready_i), .wlast_err_o(wlast_err_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_reset();
    chk("rst_wready", wready_o, 0);
    chk("rst_bvalid", bvalid_o, 0);
    chk("rst_gnt", error_gnt_o, 0);
    chk("rst_completed", wdata_error_completed_o, 0);
    chk("rst_wlast_err", wlast_err_o, 0);
    chk("rst_bid", bid_o, 0);
    chk("rst_bresp", bresp_o, 2'b11);
    chk("rst_buser", buser_o, 0);
  endtask

  // Monitor
  always @(negedge clk) begin
    beat_t e;
    int    n;
    cyc++;
    if (!rst_n) beats = 0;
    else begin
      if (wvalid_i && wready_o) begin
        if (wq.size() == 0) chk("unexpected_w_beat", 1, 0);
        else begin
          e = wq.pop_front();
          chk("wlast_err", wlast_err_o, e.err);
          beats++;
          if (e.fin) final_cyc = cyc;
        end
      end else chk("wlast_err_nobeat", wlast_err_o, 0);
      if (wdata_error_completed_o) begin
        if (cq.size() == 0) chk("unexpected_completion", 1, 0);
        else begin
          n = cq.pop_front();
          chk("burst_beats", beats, n);
          chk("completion_latency", cyc - final_cyc, 1);
          beats = 0;
        end
      end
      if (bvalid_o) begin
        if (bq.size() == 0) chk("unexpected_bvalid", 1, 0);
        else begin
          chk("bid", bid_o, bq[0]);
          chk("bresp", bresp_o, 2'b11);
          chk("buser", buser_o, 0);
          chk("error_gnt", error_gnt_o, bready_i);
          if (bready_i) void'(bq.pop_front());
        end
      end else chk("error_gnt_nobvalid", error_gnt_o, 0);
    end
  end

  // mode: 0 random wvalid, 1 toggle, 2 always. bad<0: wlast on true last beat.
  task automatic do_txn(input logic [IDW-1:0] id, input int len, input int bad,
                        input int mode, input int bp, input bit resample, input int rst_at);
    int k = 0;
    int budget;
    bit wv = 1'b0;
    bit done;
    @(posedge clk); #1;
    awid_i = id; awlen_i = len[7:0]; sample_awdata_info_i = 1'b1;
    @(posedge clk); #1;
    sample_awdata_info_i = 1'b0; awid_i = IDW'($urandom); awlen_i = 8'($urandom);
    chk("wready_armed", wready_o, 0);
    handle_error_i = 1'b1;
    @(posedge clk); #1;
    chk("wready_drain_entry", wready_o, 1);
    budget = 4 * (len + 1) + 20;
    while (k <= len) begin
      sample_awdata_info_i = 1'b0;
      if (rst_at >= 0 && k == rst_at) begin
        wvalid_i = 1'b0; handle_error_i = 1'b0; rst_n = 1'b0;
        #1;
        wq.delete(); cq.delete(); bq.delete();
        check_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if (resample && k == 3) begin
        sample_awdata_info_i = 1'b1; awid_i = ~id; awlen_i = 8'd1;
      end
      case (mode)
        0:       wv = ($urandom_range(0, 3) != 0);
        1:       wv = ~wv;
        default: wv = 1'b1;
      endcase
      wvalid_i = wv;
      wlast_i  = (bad >= 0) ? (k == bad) : (k == len);
      if (k > 0 && mode == 0) handle_error_i = 1'($urandom_range(0, 1));
      if (wv && wready_o) begin
        wq.push_back('{err: (wlast_i != (k == len)), fin: (k == len)});
        if (k == len) begin
          cq.push_back(len + 1);
          bq.push_back(id);
        end
        k++;
      end
      @(posedge clk); #1;
      budget--;
      if (budget == 0) begin
        chk("drain_timeout", 0, 1);
        break;
      end
    end
    wvalid_i = 1'b0; wlast_i = 1'b0; handle_error_i = 1'b0; sample_awdata_info_i = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 5 && !done; i++) begin
      if (wdata_error_completed_o) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("completion_seen", done, 1);
    error_req_i = 1'b1; bready_i = (bp == 0);
    @(posedge clk); #1;
    for (int i = 0; i < bp; i++) begin
      chk("gnt_backpressure", error_gnt_o, 0);
      @(posedge clk); #1;
    end
    bready_i = 1'b1;
    #1;
    chk("gnt_on_ready", error_gnt_o, 1);
    @(posedge clk); #1;
    error_req_i = 1'b0; bready_i = 1'b0;
    chk("bvalid_after_gnt", bvalid_o, 0);
  endtask

  initial begin
    int len, bad;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    do_txn(16'h0005,   0, -1, 2, 0, 1'b0, -1);
    do_txn(16'h1234,  15, -1, 1, 0, 1'b0, -1);
    do_txn(16'h00a7,   3,  1, 2, 0, 1'b0, -1);
    do_txn(16'hbeef,   2, -1, 2, 5, 1'b0, -1);
    do_txn(16'hcafe, 255, -1, 0, 1, 1'b1, -1);
    do_txn(16'h7777,   7, -1, 2, 0, 1'b0,  3);
    do_txn(16'h4242,   7, -1, 0, 2, 1'b0, -1);
    for (int t = 0; t < 25; t++) begin
      len = $urandom_range(0, 20);
      bad = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, len));
      do_txn(IDW'($urandom), len, bad, $urandom_range(0, 2), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), -1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", wq.size() + cq.size() + bq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_w_error_sink.md
# axi_w_error_sink

Write-data and write-response sink for AW transactions that decode to no reachable slave. It sits beside the per-master AW address decoder. It captures the failing transaction's ID/length when the decoder accepts an erroneous AW. While the decoder signals error handling, it absorbs the matching W burst. It then returns a DECERR B response whose handshake serves as the decoder's error grant.

## Interface
- AXI_ID_IN, default 16: width of AWID/BID.
- AXI_USER_W, default 6: width of BUSER (driven zero).
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- awid_i, in, AXI_ID_IN: AW ID of the current AW request.
- awlen_i, in, 8: AW burst length (beats − 1).
- sample_awdata_info_i, in, 1: decoder accepted an erroneous AW this cycle; capture ID/length.
- handle_error_i, in, 1: decoder permits draining the W burst.
- wdata_error_completed_o, out, 1: one-cycle pulse; erroneous W burst fully absorbed.
- error_req_i, in, 1: decoder requests the error B response.
- error_gnt_o, out, 1: B response handshake completed.
- wvalid_i, in, 1: W beat valid from the master.
- wlast_i, in, 1: W last flag from the master.
- wready_o, out, 1: W ready to the master during drain.
- bvalid_o, out, 1: error B response valid.
- bid_o, out, AXI_ID_IN: captured ID.
- bresp_o, out, 2: fixed 2'b11 (DECERR).
- buser_o, out, AXI_USER_W: zero.
- bready_i, in, 1: B ready from the master.
- wlast_err_o, out, 1: one-cycle pulse on W length/WLAST mismatch.

## Operation
- States: IDLE, ARMED, DRAIN, DONE, RESP. Reset → IDLE; id_q, len_q and beat counter cnt (9 bit) cleared.
- IDLE:
  - sample_awdata_info_i=1 → capture id_q=awid_i and len_q=awlen_i; clear cnt; go to ARMED.
  - Otherwise stay in IDLE.
- ARMED: handle_error_i=1 → DRAIN (same-cycle entry not required; transition is registered).
- DRAIN:
  - wready_o=1.
  - Each wvalid_i beat increments cnt.
  - The beat with cnt==len_q is final → DONE.
  - Termination depends only on the count, not on wlast_i.
  - wlast_err_o pulses when wlast_i=1 on a non-final beat, or wlast_i=0 on the final beat.
- DONE: wdata_error_completed_o=1 for exactly one cycle → RESP.
- RESP:
  - bvalid_o=error_req_i; bid_o=id_q.
  - bvalid_o & bready_i → error_gnt_o=1 that cycle → IDLE.
- sample_awdata_info_i outside IDLE is ignored; the decoder cannot raise a second error before granting the first.
- handle_error_i dropping during DRAIN does not abort the drain. The counter holds state; only wready_o follows the state.
- len_q=255 → 256 beats absorbed. cnt is 9 bit so no wrap occurs.
- Reset asserted mid-burst → IDLE immediately. The partial burst is discarded and no response is issued.

## Timing
- Reset values: wready_o=0, bvalid_o=0, error_gnt_o=0, wdata_error_completed_o=0, wlast_err_o=0, bid_o=0, bresp_o=2'b11, buser_o=0.
- State register updates on posedge clk; all outputs are Moore-decoded from state except bvalid_o, error_gnt_o and wlast_err_o, which are combinational.
- Final W beat accepted at cycle n → wdata_error_completed_o high at n+1 → earliest bvalid_o at n+2 (decoder registers its state).
- W handshake: beat transfers when wvalid_i & wready_o. No W beat is accepted outside DRAIN.
- B handshake: bvalid_o is held while error_req_i stays high until bready_i; error_gnt_o equals the transfer cycle.
- Minimum error turnaround: sample at t → ARMED at t+1 → DRAIN at t+2 (given handle_error_i).

## Structure
- Shared package axi_node_pkg holds:
  - the state enum (IDLE, ARMED, DRAIN, DONE, RESP; logic [2:0]);
  - RESP_DECERR=2'b11;
  - AXI_LEN_W=8.
- Single module; the counter and FSM are too small to justify a sub-module.

## Test plan
- Single-beat error: sample id=0x5, len=0; handle_error_i high; one W beat with wlast=1 → completion pulse 1 cycle later; with error_req_i and bready_i high, bvalid=1, bid=0x5, bresp=2'b11, error_gnt for 1 cycle → IDLE.
- 16-beat burst, len=15, wvalid toggled every other cycle → exactly 16 beats accepted; completion only after the 16th; no wlast_err.
- WLAST mismatch: len=3 with wlast on beat 2 → wlast_err pulse at beat 2; drain continues to beat 4; completion follows.
- B backpressure: bready_i low for 5 cycles → bvalid and bid stable, error_gnt low, then one grant cycle when bready_i rises.
- Max length: len=255 → 256 beats, cnt reaches 255 without wrap; a second sample_awdata_info_i during DRAIN is ignored and id_q is unchanged.
- Reset at beat 3 of 8 → all outputs return to reset values immediately; a new error then proceeds normally.
